uart_word_tx: RTL and testbench

- Serial transmitter for the CPU's OUT path; the sending counterpart of the board's UART receive side.
- Accepts one 32-bit word per four-phase send/recv handshake, the same handshake style as the output_sig_send/output_sig_recv pair.
- Serializes the word as four 8N1 UART frames, least-significant byte first, on the tx line.
- Sits between the cpu core's output handshake and the board UART TX pin; runs on the board clock, not clock_cpu.

---
 rtl/io_pkg.sv | 23 ++
 rtl/uart_baud_gen.sv | 37 +++
 rtl/uart_word_tx.sv | 147 ++++++++++++++
 tb/tb_uart_word_tx.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared definitions for the board-clock UART word path (tx now, rx later).
// The state encoding is shared so both directions decode the same values.
package io_pkg;

  localparam int CLK_FREQ          = 50_000_000;
  localparam int BAUD              = 115_200;
  localparam int UART_CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int WORD_BYTES        = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    ACK   = 3'd4
  } uart_state_e;

  // Byte idx of a 32-bit word, byte 0 being the least significant.
  function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
    return word[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: a one-cycle bit_end_o pulse every CLKS_PER_BIT enabled
// cycles; clr_i realigns the period to the start of a frame.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clock,
  input  logic n_reset,
  input  logic en_i,
  input  logic clr_i,
  output logic bit_end_o
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!n_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_end_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/uart_word_tx.sv
// Sends one 32-bit word per send/recv handshake as four back-to-back 8N1
// frames, least-significant byte first.
//
// state | meaning
// IDLE  | waiting for send, tx idles high
// START | start bit (tx=0)
// DATA  | eight data bits, LSB first
// STOP  | stop bit; next frame follows directly unless this was the last byte
// ACK   | word done, recv high until send falls
module uart_word_tx #(
  parameter int CLKS_PER_BIT   = io_pkg::UART_CLKS_PER_BIT,
  parameter int BYTES_PER_WORD = io_pkg::WORD_BYTES
) (
  input  logic        clock,
  input  logic        n_reset,
  input  logic        send,
  input  logic [31:0] data,
  output logic        recv,
  output logic        busy,
  output logic        tx
);

  import io_pkg::*;

  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  uart_state_e state_q, state_d;
  logic        tx_q, tx_d;
  logic        recv_q, recv_d;
  logic        busy_q, busy_d;
  logic [31:0] word_q, word_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic        bit_end, baud_en, baud_clr;

  assign baud_en  = (state_q == START) || (state_q == DATA) || (state_q == STOP);
  assign baud_clr = ((state_q == IDLE) && send) ||
                    ((state_q == STOP) && bit_end && (byte_idx_q != LAST_BYTE));

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clock    (clock),
    .n_reset  (n_reset),
    .en_i     (baud_en),
    .clr_i    (baud_clr),
    .bit_end_o(bit_end)
  );

  always_ff @(posedge clock) begin
    if (!n_reset) begin
      state_q    <= IDLE;
      tx_q       <= 1'b1;
      recv_q     <= 1'b0;
      busy_q     <= 1'b0;
      word_q     <= '0;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      recv_q     <= recv_d;
      busy_q     <= busy_d;
      word_q     <= word_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (send) state_d = START;
      START:   if (bit_end) state_d = DATA;
      DATA:    if (bit_end && (bit_idx_q == 3'd7)) state_d = STOP;
      STOP:    if (bit_end) state_d = (byte_idx_q == LAST_BYTE) ? ACK : START;
      ACK:     if (!send) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Register next values are computed here so every output comes from a flop.
  always_comb begin
    tx_d       = tx_q;
    recv_d     = recv_q;
    busy_d     = busy_q;
    word_d     = word_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    unique case (state_q)
      IDLE: begin
        if (send) begin
          word_d     = data;
          shift_d    = word_byte(data, 2'd0);
          tx_d       = 1'b0;
          busy_d     = 1'b1;
          byte_idx_d = '0;
          bit_idx_d  = '0;
        end
      end
      START: begin
        if (bit_end) begin
          bit_idx_d = '0;
          tx_d      = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d   = shift_q >> 1;
          bit_idx_d = bit_idx_q + 3'd1;
          tx_d      = (bit_idx_q == 3'd7) ? 1'b1 : shift_q[1];
        end
      end
      STOP: begin
        if (bit_end) begin
          if (byte_idx_q != LAST_BYTE) begin
            byte_idx_d = byte_idx_q + 2'd1;
            shift_d    = word_byte(word_q, byte_idx_q + 2'd1);
            tx_d       = 1'b0;
          end else begin
            recv_d = 1'b1;
          end
        end
      end
      ACK: begin
        if (!send) begin
          recv_d = 1'b0;
          busy_d = 1'b0;
        end
      end
      default: begin
        tx_d   = 1'b1;
        recv_d = 1'b0;
        busy_d = 1'b0;
      end
    endcase
  end

  assign tx   = tx_q;
  assign recv = recv_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_uart_word_tx.sv
// Randomized bench for uart_word_tx: a driver issues words and pushes the
// expected frames into a queue; an independent UART monitor decodes tx.
module tb_uart_word_tx;

  localparam int CPB = 4;

  typedef struct {
    logic [7:0] b;
    int         start;
  } frame_t;

  logic        clock;
  logic        n_reset;
  logic        send;
  logic [31:0] data;
  logic        recv;
  logic        busy;
  logic        tx;

  int     cyc;
  int     checks;
  int     errors;
  bit     mon_en;
  frame_t exp_q[$];

  uart_word_tx #(
    .CLKS_PER_BIT  (CPB),
    .BYTES_PER_WORD(4)
  ) dut (
    .clock  (clock),
    .n_reset(n_reset),
    .send   (send),
    .data   (data),
    .recv   (recv),
    .busy   (busy),
    .tx     (tx)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clock);
      cyc++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at cycle %0d, required to finish", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Expected frames come straight from the word: byte i is (w >> 8i) & 0xFF,
  // and frame i starts 10*CPB*i cycles after the first start-bit cycle.
  task automatic push_word(input logic [31:0] w, input int acc, input int nbytes);
    frame_t e;
    for (int i = 0; i < nbytes; i++) begin
      e.b     = 8'((w >> (8 * i)) & 32'hFF);
      e.start = acc + 10 * CPB * i;
      exp_q.push_back(e);
    end
  endtask

  // Sends one word from idle. early: send high for one cycle only; otherwise
  // send is held for hold cycles past recv rising.
  task automatic send_word(input logic [31:0] w, input bit early, input int hold);
    int acc, r, drop, fall;
    send = 1'b1;
    data = w;
    acc  = cyc + 1;
    r    = acc + 40 * CPB;
    drop = acc;
    push_word(w, acc, 4);
    tick();
    chk("accept_tx_low", tx, 0);
    chk("accept_busy", busy, 1);
    data = $urandom;
    if (early) begin
      send = 1'b0;
      drop = cyc;
    end
    while (cyc < r - 1) tick();
    chk("pre_recv_low", recv, 0);
    chk("pre_recv_busy", busy, 1);
    tick();
    chk("recv_rise", recv, 1);
    chk("ack_tx_idle", tx, 1);
    if (!early) begin
      for (int h = 0; h < hold; h++) begin
        tick();
        chk("ack_hold_recv", recv, 1);
        chk("ack_hold_tx", tx, 1);
      end
      send = 1'b0;
      drop = cyc;
    end
    fall = (drop + 1 > r + 1) ? drop + 1 : r + 1;
    while (cyc < fall) tick();
    chk("recv_fall", recv, 0);
    chk("busy_fall", busy, 0);
  endtask

  initial begin : uart_mon
    frame_t     e;
    logic [7:0] got;
    logic       sbit, pbit;
    int         st;
    bit         aborted;
    forever begin
      @(negedge clock);
      if (mon_en && n_reset && tx === 1'b0) begin
        st      = cyc;
        aborted = 1'b0;
        got     = '0;
        sbit    = 1'b1;
        pbit    = 1'b0;
        for (int s = 1; s <= 9 * CPB + CPB / 2; s++) begin
          @(negedge clock);
          if (!n_reset) aborted = 1'b1;
          if (s % CPB == CPB / 2) begin
            if (s / CPB == 0)      sbit = tx;
            else if (s / CPB == 9) pbit = tx;
            else                   got[s / CPB - 1] = tx;
          end
        end
        if (!aborted) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame at cycle %0d: got byte %02h, no frame expected", st, got);
          end else begin
            e = exp_q.pop_front();
            chk("frame_byte", got, e.b);
            chk("frame_start_cycle", st, e.start);
            chk("frame_start_bit", sbit, 0);
            chk("frame_stop_bit", pbit, 1);
          end
        end
      end
    end
  end

  initial begin : driver
    int acc;
    checks  = 0;
    errors  = 0;
    mon_en  = 1'b0;
    n_reset = 1'b0;
    send    = 1'b1;
    data    = $urandom;

    for (int i = 0; i < 5; i++) begin
      tick();
      chk("reset_tx", tx, 1);
      chk("reset_recv", recv, 0);
      chk("reset_busy", busy, 0);
    end
    send    = 1'b0;
    n_reset = 1'b1;
    mon_en  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_tx", tx, 1);
      chk("idle_busy", busy, 0);
    end

    send_word(32'h0000_00A5, 1'b0, 3);
    send_word(32'h1234_5678, 1'b0, 0);
    send_word(32'hDEAD_BEEF, 1'b1, 0);

    // Reset during data bit 3 of byte 1: only byte 0 may complete.
    send = 1'b1;
    data = $urandom;
    acc  = cyc + 1;
    push_word(data, acc, 1);
    tick();
    send = 1'b0;
    while (cyc < acc + 14 * CPB + 1) tick();
    n_reset = 1'b0;
    tick();
    chk("midreset_tx", tx, 1);
    chk("midreset_busy", busy, 0);
    chk("midreset_recv", recv, 0);
    tick();
    tick();
    n_reset = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 12 * CPB; i++) begin
      tick();
      chk("post_reset_idle_tx", tx, 1);
    end
    send_word(32'h0000_003C, 1'b0, 2);

    // send held through ACK, low for one cycle, then the next word.
    send_word($urandom, 1'b0, 6);
    send_word(32'h0000_0001, 1'b0, 1);

    for (int k = 0; k < 10; k++) begin
      repeat ($urandom_range(0, 3)) tick();
      send_word($urandom, ($urandom_range(0, 2) == 0), $urandom_range(0, 5));
    end

    repeat (2 * CPB) tick();
    chk("all_frames_seen", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
